// File: rtl/periph_bus_master_if.sv
// Core request/response handshake plus the peripheral register port of periph_bus_master.
// The master modport is the bus master's view; the slave modport is the view of whatever surrounds it.
interface periph_bus_master_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [DW-1:0] req_mask;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  logic          p_we;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;
  logic [DW-1:0] p_rdata;

  modport master (
    input  req_valid, req_op, req_addr, req_wdata, req_mask, rsp_ready, p_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, p_we, p_addr, p_wdata
  );

  modport slave (
    output req_valid, req_op, req_addr, req_wdata, req_mask, rsp_ready, p_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, p_we, p_addr, p_wdata
  );
endinterface

// File: rtl/periph_bus_master.sv
// Single-outstanding bus master: turns core read/write/masked-RMW requests into peripheral register cycles.
// Define PBM_VERIFY_EN to add a read-back VERIFY cycle after every write that flags mismatches in rsp_err.
module periph_bus_master #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic                clk,
  input logic                rst,
  periph_bus_master_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCESS = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_RESP   = 3'd3;
`ifdef PBM_VERIFY_EN
  localparam logic [2:0] S_VERIFY = 3'd4;
`endif

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RMW   = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  logic [2:0]    state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] mask_q, mask_d;
  logic          p_we_q, p_we_d;
  logic [AW-1:0] p_addr_q, p_addr_d;
  logic [DW-1:0] p_wdata_q, p_wdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  logic [DW-1:0] merged;
`ifdef PBM_VERIFY_EN
  logic [DW-1:0] cmp_mask;
  assign cmp_mask = (op_q == OP_RMW) ? mask_q : '1;
`endif

  // Replace only the masked bits of the value read back during ACCESS.
  assign merged = (bus.p_rdata & ~mask_q) | (wdata_q & mask_q);

  always_comb begin
    // NOTE: every _d defaults to its flop (p_we_d to 0) before the case, so no path can infer a latch.
    state_d     = state_q;
    op_d        = op_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    p_we_d      = 1'b0;
    p_addr_d    = p_addr_q;
    p_wdata_d   = p_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          wdata_d = bus.req_wdata;
          mask_d  = bus.req_mask;
          if (bus.req_op == OP_RSVD) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end else begin
            state_d  = S_ACCESS;
            p_addr_d = bus.req_addr;
            if (bus.req_op == OP_WRITE) begin
              p_we_d    = 1'b1;
              p_wdata_d = bus.req_wdata;
            end
          end
        end
      end

      S_ACCESS: begin
        case (op_q)
          OP_READ: begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = bus.p_rdata;
            rsp_err_d   = 1'b0;
          end
          OP_WRITE: begin
`ifdef PBM_VERIFY_EN
            state_d     = S_VERIFY;
`else
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = p_wdata_q;
            rsp_err_d   = 1'b0;
`endif
          end
          OP_RMW: begin
            state_d   = S_WRITE;
            p_we_d    = 1'b1;
            p_wdata_d = merged;
          end
          default: state_d = S_IDLE;
        endcase
      end

      S_WRITE: begin
`ifdef PBM_VERIFY_EN
        state_d     = S_VERIFY;
`else
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = p_wdata_q;
        rsp_err_d   = 1'b0;
`endif
      end

`ifdef PBM_VERIFY_EN
      // p_wdata_q still holds the written value; input-mode bits show up as a read-back mismatch.
      S_VERIFY: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = p_wdata_q;
        rsp_err_d   = |((bus.p_rdata ^ p_wdata_q) & cmp_mask);
      end
`endif

      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_READ;
      wdata_q     <= '0;
      mask_q      <= '0;
      p_we_q      <= 1'b0;
      p_addr_q    <= '0;
      p_wdata_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      p_we_q      <= p_we_d;
      p_addr_q    <= p_addr_d;
      p_wdata_q   <= p_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.p_we      = p_we_q;
  assign bus.p_addr    = p_addr_q;
  assign bus.p_wdata   = p_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_periph_bus_master.sv
// Bench for periph_bus_master: GPIO-like slave, transaction-level reference model with a per-cycle
// compare process, directed literal cases, then randomized traffic. Honors PBM_VERIFY_EN if defined.
module tb_periph_bus_master;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef PBM_VERIFY_EN
  localparam int VFY = 1;
`else
  localparam int VFY = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  periph_bus_master_if #(.AW(AW), .DW(DW)) bus ();
  periph_bus_master #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int we_count = 0;
  bit mon_en = 1'b0;

  // Slave: four registers decoded on addr[3:2]; force_mask models input-mode bits of the data register.
  logic [31:0] periph_mem [4];
  logic [31:0] ref_mem [4];
  logic [31:0] force_mask = 32'h0;

  assign bus.p_rdata = periph_mem[bus.p_addr[3:2]] &
                       ~((bus.p_addr[3:2] == 2'd1) ? force_mask : 32'h0);

  always @(posedge clk) begin
    if (bus.p_we) begin
      periph_mem[bus.p_addr[3:2]] <= bus.p_wdata;
      we_count <= we_count + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem[a[3:2]] & ~((a[3:2] == 2'd1) ? force_mask : 32'h0);
  endfunction

  // Reference model: on accept, derive write cycle, latency and response from the op rules alone.
  initial begin
    bit          busy = 1'b0;
    bit          rst_pending = 1'b0;
    int          cyc = 0, lat = 0, wr_cyc = 0;
    logic [1:0]  t_op;
    logic [31:0] t_addr, old_v, new_v, wr_data, exp_rdata;
    logic [31:0] exp_paddr = 32'h0, exp_pwdata = 32'h0;
    logic        exp_err = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rst_pending) begin
          check("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
          check("reset_rsp_err", bus.rsp_err, 1'b0);
          rst_pending = 1'b0;
        end
        if (busy) begin
          cyc++;
          if (cyc == 1 && t_op != 2'b11) exp_paddr = t_addr;
          if (cyc == wr_cyc) exp_pwdata = wr_data;
          check("req_ready_busy", bus.req_ready, 1'b0);
          check("p_we", bus.p_we, cyc == wr_cyc);
          check("p_addr", bus.p_addr, exp_paddr);
          check("p_wdata", bus.p_wdata, exp_pwdata);
          check("rsp_valid", bus.rsp_valid, cyc >= lat);
          if (cyc >= lat) begin
            check("rsp_rdata", bus.rsp_rdata, exp_rdata);
            check("rsp_err", bus.rsp_err, exp_err);
            if (bus.rsp_ready) busy = 1'b0;
          end
        end else begin
          check("req_ready_idle", bus.req_ready, 1'b1);
          check("p_we_idle", bus.p_we, 1'b0);
          check("rsp_valid_idle", bus.rsp_valid, 1'b0);
          check("p_addr_idle", bus.p_addr, exp_paddr);
          check("p_wdata_idle", bus.p_wdata, exp_pwdata);
          if (rst && bus.req_valid) begin
            busy   = 1'b1;
            cyc    = 0;
            t_op   = bus.req_op;
            t_addr = bus.req_addr;
            old_v  = ref_rd(t_addr);
            wr_cyc = 0;
            case (t_op)
              2'b00: begin
                lat = 2; exp_rdata = old_v; exp_err = 1'b0;
              end
              2'b01: begin
                wr_data = bus.req_wdata; wr_cyc = 1; lat = 2 + VFY;
                ref_mem[t_addr[3:2]] = wr_data;
                exp_rdata = wr_data;
                exp_err = (VFY != 0) && (ref_rd(t_addr) != wr_data);
              end
              2'b10: begin
                new_v = (old_v & ~bus.req_mask) | (bus.req_wdata & bus.req_mask);
                wr_data = new_v; wr_cyc = 2; lat = 3 + VFY;
                ref_mem[t_addr[3:2]] = new_v;
                exp_rdata = new_v;
                exp_err = (VFY != 0) && (((ref_rd(t_addr) ^ new_v) & bus.req_mask) != 32'h0);
              end
              default: begin
                lat = 1; exp_rdata = 32'h0; exp_err = 1'b1;
              end
            endcase
          end
        end
        if (!rst) begin
          busy = 1'b0;
          rst_pending = 1'b1;
          exp_paddr = 32'h0;
          exp_pwdata = 32'h0;
        end
      end
    end
  end

  task automatic preload(input int idx, input logic [31:0] v);
    periph_mem[idx] <= v;
    ref_mem[idx] = v;
  endtask

  // One request; returns response data, error flag and cycles from accept cycle to first rsp_valid.
  task automatic do_req(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] mask, input int hold,
                        output logic [31:0] rdata, output logic err, output int lat);
    int guard = 0;
    @(posedge clk); #1;
    bus.req_op = op; bus.req_addr = addr; bus.req_wdata = wdata; bus.req_mask = mask;
    bus.req_valid = 1'b1;
    bus.rsp_ready = (hold == 0);
    do begin
      @(negedge clk);
      guard++;
    end while (!bus.req_ready && guard < 50);
    check("accept_wait", guard < 50, 1'b1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_op = 2'($urandom); bus.req_addr = $urandom; bus.req_wdata = $urandom; bus.req_mask = $urandom;
    lat = 0;
    do begin
      lat++;
      @(negedge clk);
    end while (!bus.rsp_valid && lat < 50);
    check("rsp_wait", lat < 50, 1'b1);
    rdata = bus.rsp_rdata;
    err = bus.rsp_err;
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1 bus.rsp_ready = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, wd, mk, ad;
    logic        er;
    int          lt, w0;
    logic [1:0]  op;
    for (int i = 0; i < 4; i++) preload(i, 32'h0);
    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_mask = '0; bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("init_req_ready", bus.req_ready, 1'b1);
    check("init_rsp_valid", bus.rsp_valid, 1'b0);
    check("init_p_addr", bus.p_addr, 32'h0);

    w0 = we_count;
    do_req(2'b01, 32'h0, 32'h5, 32'h0, 0, rd, er, lt);
    check("wr_rdata", rd, 32'h5);
    check("wr_err", er, 1'b0);
    check("wr_lat", lt, 2 + VFY);
    check("wr_pulses", we_count - w0, 1);
    check("wr_ctrl", periph_mem[0], 32'h5);

    preload(1, 32'h3);
    w0 = we_count;
    do_req(2'b00, 32'h4, 32'h0, 32'h0, 0, rd, er, lt);
    check("rd_rdata", rd, 32'h3);
    check("rd_lat", lt, 2);
    check("rd_pulses", we_count - w0, 0);

    preload(1, 32'hF0F0_F0F0);
    w0 = we_count;
    do_req(2'b10, 32'h4, 32'h0000_00FF, 32'h0000_000F, 0, rd, er, lt);
    check("rmw_rdata", rd, 32'hF0F0_F0FF);
    check("rmw_lat", lt, 3 + VFY);
    check("rmw_pulses", we_count - w0, 1);
    check("rmw_mem", periph_mem[1], 32'hF0F0_F0FF);

    do_req(2'b00, 32'h4, 32'h0, 32'h0, 5, rd, er, lt);
    check("bp_rdata", rd, 32'hF0F0_F0FF);
    check("bp_lat", lt, 2);

    w0 = we_count;
    do_req(2'b11, 32'h8, 32'h1234, 32'hFFFF, 0, rd, er, lt);
    check("rsvd_rdata", rd, 32'h0);
    check("rsvd_err", er, 1'b1);
    check("rsvd_lat", lt, 1);
    check("rsvd_pulses", we_count - w0, 0);
    check("rsvd_p_addr", bus.p_addr, 32'h4);

    @(posedge clk); #1;
    bus.req_op = 2'b10; bus.req_addr = 32'h0; bus.req_wdata = 32'hA0; bus.req_mask = 32'hF0;
    bus.req_valid = 1'b1; bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("rst_test_accept", bus.req_ready, 1'b1);
    @(posedge clk); #1 bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_test_we", bus.p_we, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("rst_p_we", bus.p_we, 1'b0);
    check("rst_p_addr", bus.p_addr, 32'h0);
    check("rst_p_wdata", bus.p_wdata, 32'h0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_req_ready", bus.req_ready, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("rst_no_rsp", bus.rsp_valid, 1'b0);
    end
    check("rst_rmw_mem", periph_mem[0], 32'hA5);

    force_mask = 32'h1;
    preload(1, 32'h0);
    do_req(2'b01, 32'h4, 32'h1, 32'h0, 0, rd, er, lt);
    check("vfy_rdata", rd, 32'h1);
    check("vfy_err", er, VFY[0]);
    check("vfy_lat", lt, 2 + VFY);
    force_mask = 32'h0;

    for (int n = 0; n < 150; n++) begin
      op = 2'($urandom_range(0, 3));
      ad = $urandom;
      wd = $urandom;
      mk = $urandom;
      force_mask = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
      do_req(op, ad, wd, mk, $urandom_range(0, 3), rd, er, lt);
    end

    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) check("final_mem", periph_mem[i], ref_mem[i]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
